// File: rtl/tok_lookahead_ctrl.sv
// Lookahead token queue between lexer and parser; executes PEEK/CONSUME/EXPECT/EXPECT_KIND on the head token.
// Optional first-error position capture is enabled by defining TOK_LOOKAHEAD_ERRPOS_EN.
module tok_lookahead_ctrl #(
    parameter int CODE_W = 16,
    parameter int DEPTH  = 4,
    parameter int POS_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic [2:0]        tok_kind,
    input  logic [CODE_W-1:0] tok_code,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_kind,
    input  logic [CODE_W-1:0] cmd_code,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [2:0]        rsp_kind,
    output logic [CODE_W-1:0] rsp_code,
    output logic [POS_W-1:0]  pos,
    output logic              err,
    output logic [POS_W-1:0]  err_pos
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] KIND_RESERVED = 3'd0;
    localparam logic [2:0] KIND_EOF      = 3'd4;

    typedef enum logic {ST_RUN, ST_ERR} state_t;
    typedef enum logic [1:0] {OP_PEEK, OP_CONSUME, OP_EXPECT, OP_EXPECT_KIND} op_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              r_eof_seen;
    logic [2:0]        r_q_kind [DEPTH];
    logic [CODE_W-1:0] r_q_code [DEPTH];
    logic              r_rsp_valid;
    logic              r_rsp_hit;
    logic [2:0]        r_rsp_kind;
    logic [CODE_W-1:0] r_rsp_code;
    logic [POS_W-1:0]  r_pos;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_accept;
    logic              w_hit;
    logic              w_pop;
    logic              w_fault;
    logic [2:0]        w_head_kind;
    logic [CODE_W-1:0] w_head_code;
    op_t               w_op;

    // Extra wrap bit distinguishes full from empty when the index bits coincide.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head_kind = r_q_kind[r_rd_ptr[AW-1:0]];
    assign w_head_code = r_q_code[r_rd_ptr[AW-1:0]];
    assign w_op        = op_t'(cmd_op);

    assign tok_ready = !w_full && !r_eof_seen;
    assign w_push    = tok_valid && tok_ready;

    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers sample pre-edge values together.
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: each signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        w_pop       = 1'b0;
        w_fault     = 1'b0;
        cmd_ready   = (r_state == ST_RUN) && !w_empty;
        w_accept    = cmd_valid && cmd_ready;

        if (w_op == OP_EXPECT_KIND) w_hit = (w_head_kind == cmd_kind);
        else                        w_hit = (w_head_kind == KIND_RESERVED) && (w_head_code == cmd_code);

        if (w_accept) begin
            case (w_op)
                OP_PEEK: ;
                OP_CONSUME:
                    w_pop = w_hit && (w_head_kind != KIND_EOF);
                OP_EXPECT, OP_EXPECT_KIND: begin
                    w_pop   = w_hit && (w_head_kind != KIND_EOF);
                    w_fault = !w_hit;
                end
                default: ;
            endcase
        end
        if (w_fault) w_state_nxt = ST_ERR;
    end

    // NOTE: queue storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_kind[r_wr_ptr[AW-1:0]] <= tok_kind;
            r_q_code[r_wr_ptr[AW-1:0]] <= tok_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_eof_seen  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_kind  <= '0;
            r_rsp_code  <= '0;
            r_pos       <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                if (tok_kind == KIND_EOF) r_eof_seen <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                if (!(&r_pos)) r_pos <= r_pos + POS_W'(1);
            end
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_hit  <= w_hit;
                r_rsp_kind <= w_head_kind;
                r_rsp_code <= w_head_code;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_kind  = r_rsp_kind;
    assign rsp_code  = r_rsp_code;
    assign pos       = r_pos;
    assign err       = (r_state == ST_ERR);

`ifdef TOK_LOOKAHEAD_ERRPOS_EN
    logic [POS_W-1:0] r_err_pos;

    // A fault can only occur in RUN, so this captures the first error position only.
    always_ff @(posedge clk) begin
        if (rst)          r_err_pos <= '0;
        else if (w_fault) r_err_pos <= r_pos;
    end
    assign err_pos = r_err_pos;
`else
    assign err_pos = '0;
`endif

endmodule

// File: tb/tb_tok_lookahead_ctrl.sv
// Randomized and directed bench for tok_lookahead_ctrl, checked cycle by cycle against a queue-based model.
// A narrow position counter is used so pos saturation is reached within the run.
module tb_tok_lookahead_ctrl;

    localparam int CODE_W  = 16;
    localparam int DEPTH   = 4;
    localparam int POS_W   = 4;
    localparam int POS_MAX = (1 << POS_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tok_valid = 1'b0;
    logic              tok_ready;
    logic [2:0]        tok_kind = '0;
    logic [CODE_W-1:0] tok_code = '0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [2:0]        cmd_kind = '0;
    logic [CODE_W-1:0] cmd_code = '0;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [2:0]        rsp_kind;
    logic [CODE_W-1:0] rsp_code;
    logic [POS_W-1:0]  pos;
    logic              err;
    logic [POS_W-1:0]  err_pos;

    tok_lookahead_ctrl #(.CODE_W(CODE_W), .DEPTH(DEPTH), .POS_W(POS_W)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_code(tok_code),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_kind(cmd_kind),
        .cmd_code(cmd_code),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_kind(rsp_kind), .rsp_code(rsp_code),
        .pos(pos), .err(err), .err_pos(err_pos)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: token queue plus parser-visible state.
    logic [2:0]        q_kind [$];
    logic [CODE_W-1:0] q_code [$];
    bit                m_eof, m_err;
    int                m_pos, m_err_pos;
    bit                e_rv, e_hit;
    logic [2:0]        e_kind;
    logic [CODE_W-1:0] e_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit tv, input logic [2:0] tk,
                                input logic [CODE_W-1:0] tc, input bit cv, input logic [1:0] op,
                                input logic [2:0] ck, input logic [CODE_W-1:0] cc);
        bit full_before, acc, hit;
        if (r) begin
            q_kind.delete(); q_code.delete();
            m_eof = 0; m_err = 0; m_pos = 0; m_err_pos = 0;
            e_rv = 0; e_hit = 0; e_kind = '0; e_code = '0;
            return;
        end
        full_before = (q_kind.size() >= DEPTH);
        acc = cv && !m_err && (q_kind.size() > 0);
        e_rv = acc;
        if (acc) begin
            hit = (op == 2'd3) ? (q_kind[0] == ck) : (q_kind[0] == 3'd0 && q_code[0] == cc);
            e_hit = hit; e_kind = q_kind[0]; e_code = q_code[0];
            if (op != 2'd0 && hit && q_kind[0] != 3'd4) begin
                void'(q_kind.pop_front()); void'(q_code.pop_front());
                if (m_pos < POS_MAX) m_pos++;
            end
            if (op >= 2'd2 && !hit) begin
                m_err = 1;
                m_err_pos = m_pos;
            end
        end
        if (tv && !full_before && !m_eof) begin
            q_kind.push_back(tk); q_code.push_back(tc);
            if (tk == 3'd4) m_eof = 1;
        end
    endtask

    task automatic check_all();
        check("tok_ready", 32'(tok_ready), 32'(!m_eof && q_kind.size() < DEPTH));
        check("cmd_ready", 32'(cmd_ready), 32'(!m_err && q_kind.size() > 0));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check("rsp_hit", 32'(rsp_hit), 32'(e_hit));
        check("rsp_kind", 32'(rsp_kind), 32'(e_kind));
        check("rsp_code", 32'(rsp_code), 32'(e_code));
        check("pos", 32'(pos), 32'(m_pos));
        check("err", 32'(err), 32'(m_err));
`ifdef TOK_LOOKAHEAD_ERRPOS_EN
        check("err_pos", 32'(err_pos), 32'(m_err_pos));
`else
        check("err_pos", 32'(err_pos), 32'd0);
`endif
    endtask

    // Drive one cycle of inputs (called just after a falling edge), then check at the next falling edge.
    task automatic step(input bit r, input bit tv, input logic [2:0] tk, input logic [CODE_W-1:0] tc,
                        input bit cv, input logic [1:0] op, input logic [2:0] ck,
                        input logic [CODE_W-1:0] cc);
        rst = r; tok_valid = tv; tok_kind = tk; tok_code = tc;
        cmd_valid = cv; cmd_op = op; cmd_kind = ck; cmd_code = cc;
        model_update(r, tv, tk, tc, cv, op, ck, cc);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic push(input logic [2:0] k, input logic [CODE_W-1:0] c);
        step(0, 1, k, c, 0, 0, 0, 0);
    endtask
    task automatic cmd(input logic [1:0] op, input logic [2:0] k, input logic [CODE_W-1:0] c);
        step(0, 0, 0, 0, 1, op, k, c);
    endtask

    // safe=1 steers EXPECT/EXPECT_KIND to match the model head so no fault occurs.
    task automatic rand_step(input bit safe);
        bit tv, cv, r;
        logic [2:0] tk, ck;
        logic [CODE_W-1:0] tc, cc;
        logic [1:0] op;
        int sel;
        tv  = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 99);
        if (sel < 60)                 tk = 3'd0;
        else if (sel < 97 || safe)    tk = 3'($urandom_range(1, 3));
        else                          tk = 3'd4;
        tc  = CODE_W'($urandom_range(0, 3));
        cv  = ($urandom_range(0, 2) != 0);
        op  = 2'($urandom_range(0, 3));
        ck  = 3'($urandom_range(0, 4));
        cc  = CODE_W'($urandom_range(0, 3));
        if (safe && op >= 2'd2 && q_kind.size() > 0) begin
            ck = q_kind[0];
            cc = q_code[0];
            if (q_kind[0] != 3'd0) op = 2'd3;
        end
        r = !safe && (($urandom_range(0, 39) == 0) || (m_err && $urandom_range(0, 7) == 0));
        step(r, tv, tk, tc, cv, op, ck, cc);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("reset_empty_cmd_ready", 32'(cmd_ready), 32'd0);

        // '(' ident eof; CONSUME 5 then EXPECT_KIND ident.
        push(3'd0, 16'd5); push(3'd1, 16'd9); push(3'd4, 16'd0);
        cmd(2'd1, 3'd0, 16'd5);
        check("s1_consume_hit", 32'(rsp_hit), 32'd1);
        check("s1_pos1", 32'(pos), 32'd1);
        cmd(2'd3, 3'd1, 16'd0);
        check("s1_ident_code", 32'(rsp_code), 32'd9);
        check("s1_pos2", 32'(pos), 32'd2);

        // PEEK then CONSUME miss on ';'.
        do_reset();
        push(3'd0, 16'd7);
        cmd(2'd0, 3'd0, 16'd7);
        check("s2_peek_hit", 32'(rsp_hit), 32'd1);
        cmd(2'd1, 3'd0, 16'd6);
        check("s2_consume_miss", 32'(rsp_hit), 32'd0);
        check("s2_no_err", 32'(err), 32'd0);
        cmd(2'd0, 3'd0, 16'd7);
        check("s2_head_kept", 32'(rsp_code), 32'd7);

        // EXPECT miss on num 42 after one pop, then reset right after.
        do_reset();
        push(3'd0, 16'd1); push(3'd2, 16'd42);
        cmd(2'd1, 3'd0, 16'd1);
        cmd(2'd2, 3'd0, 16'd7);
        check("s3_err", 32'(err), 32'd1);
        check("s3_cmd_ready", 32'(cmd_ready), 32'd0);
        check("s3_code", 32'(rsp_code), 32'd42);
        step(0, 0, 0, 0, 1, 2'd0, 0, 0);
        do_reset();
        check("s6_err_clr", 32'(err), 32'd0);
        check("s6_tok_ready", 32'(tok_ready), 32'd1);

        // Fill, pop one, push fifth, drain in order.
        for (int i = 0; i < 4; i++) push(3'd0, CODE_W'(10 + i));
        check("s4_full", 32'(tok_ready), 32'd0);
        cmd(2'd1, 3'd0, 16'd10);
        check("s4_ready_again", 32'(tok_ready), 32'd1);
        push(3'd0, 16'd14);
        for (int i = 11; i <= 14; i++) begin
            cmd(2'd1, 3'd0, CODE_W'(i));
            check("s4_order", 32'(rsp_hit), 32'd1);
        end

        // eof-only: never popped, no further ingress.
        do_reset();
        push(3'd4, 16'd0);
        cmd(2'd3, 3'd4, 16'd0);
        check("s5_eof_hit", 32'(rsp_hit), 32'd1);
        check("s5_pos0", 32'(pos), 32'd0);
        push(3'd0, 16'd3);
        check("s5_no_ingress", 32'(tok_ready), 32'd0);
        cmd(2'd0, 3'd0, 16'd0);
        check("s5_eof_head", 32'(rsp_kind), 32'd4);

        // Fault-free random traffic (drives pos into saturation), then fully random with resets.
        do_reset();
        for (int i = 0; i < 2000; i++) rand_step(1'b1);
        check("sat_reached", 32'(pos), 32'(POS_MAX));
        for (int i = 0; i < 4000; i++) rand_step(1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
